// File: rtl/led_chaser_multi.sv
// LED pattern generator: a prescaler produces a step tick, and each tick advances
// the LED bank in one of four modes (rotate right, rotate left, bounce, bar fill).
module led_chaser_multi #(
  parameter int WIDTH = 8,
  parameter int DIV   = 524288
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iEN,
  input  logic [1:0]       iMODE,
  output logic [WIDTH-1:0] oLED,
  output logic             oTICK
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    MODE_RR     = 2'b00,
    MODE_RL     = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BAR    = 2'b11
  } mode_t;

  logic [CNT_W-1:0] cnt_r, cntNext_s;
  logic [WIDTH-1:0] led_r, ledNext_s;
  mode_t            mode_r, modeNext_s, reqMode_s;
  logic             dirLeft_r, dirLeftNext_s;
  logic             tick_s, tick_r;

  function automatic logic [WIDTH-1:0] startPattern(input mode_t m);
    case (m)
      MODE_RR:     startPattern = MSB_ONLY;
      MODE_RL:     startPattern = LSB_ONLY;
      MODE_BOUNCE: startPattern = MSB_ONLY;
      MODE_BAR:    startPattern = ALL_ZERO;
      default:     startPattern = MSB_ONLY;
    endcase
  endfunction

  // Prescaler advance, mode-change handling and per-mode pattern step.
  always_comb begin
    cntNext_s     = cnt_r;
    ledNext_s     = led_r;
    modeNext_s    = mode_r;
    dirLeftNext_s = dirLeft_r;
    reqMode_s     = mode_t'(iMODE);
    tick_s        = iEN && (cnt_r == CNT_MAX);

    if (iEN) begin
      cntNext_s = tick_s ? CNT_ZERO : (cnt_r + CNT_ONE);
    end else begin
      cntNext_s = cnt_r;
    end

    if (!tick_s) begin
      ledNext_s = led_r;
    end else if (reqMode_s != mode_r) begin
      // A mode change only loads the start pattern; the shift waits for the next tick.
      modeNext_s = reqMode_s;
      ledNext_s  = startPattern(reqMode_s);
      if (reqMode_s == MODE_BOUNCE) begin
        dirLeftNext_s = 1'b0;
      end else begin
        dirLeftNext_s = dirLeft_r;
      end
    end else begin
      case (mode_r)
        MODE_RR: begin
          if (led_r == ALL_ZERO) ledNext_s = MSB_ONLY;
          else                   ledNext_s = {led_r[0], led_r[WIDTH-1:1]};
        end
        MODE_RL: begin
          if (led_r == ALL_ZERO) ledNext_s = LSB_ONLY;
          else                   ledNext_s = {led_r[WIDTH-2:0], led_r[WIDTH-1]};
        end
        MODE_BOUNCE: begin
          // Direction flips on the step that lands on an end bit, so ends never dwell.
          if (led_r == ALL_ZERO) begin
            ledNext_s     = MSB_ONLY;
            dirLeftNext_s = 1'b0;
          end else if (!dirLeft_r) begin
            ledNext_s     = {1'b0, led_r[WIDTH-1:1]};
            dirLeftNext_s = led_r[1];
          end else begin
            ledNext_s     = {led_r[WIDTH-2:0], 1'b0};
            dirLeftNext_s = ~led_r[WIDTH-2];
          end
        end
        MODE_BAR: begin
          if (led_r == ALL_ONES) ledNext_s = ALL_ZERO;
          else                   ledNext_s = {1'b1, led_r[WIDTH-1:1]};
        end
        default: begin
          ledNext_s = MSB_ONLY;
        end
      endcase
    end
  end

  // State registers with synchronous reset taking priority over any tick.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_r     <= CNT_ZERO;
      led_r     <= MSB_ONLY;
      mode_r    <= MODE_RR;
      dirLeft_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      cnt_r     <= cntNext_s;
      led_r     <= ledNext_s;
      mode_r    <= modeNext_s;
      dirLeft_r <= dirLeftNext_s;
      tick_r    <= tick_s;
    end
  end

  assign oLED  = led_r;
  assign oTICK = tick_r;

endmodule

// File: tb/tb_led_chaser_multi.sv
// Directed bench for led_chaser_multi (WIDTH=4, DIV=4) with a small WIDTH=3, DIV=3
// instance checked once for a non-power-of-two prescaler.
module tb_led_chaser_multi;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iEN  = 1'b0;
  logic [1:0] iMODE = 2'b00;
  logic [3:0] oLED;
  logic       oTICK;
  logic [2:0] led2;
  logic       tick2;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] expLed;

  led_chaser_multi #(.WIDTH(4), .DIV(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iMODE(iMODE), .oLED(oLED), .oTICK(oTICK)
  );

  led_chaser_multi #(.WIDTH(3), .DIV(3)) dut2 (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iMODE(iMODE), .oLED(led2), .oTICK(tick2)
  );

  always #5 iCLK = ~iCLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic chk(input string tag, input logic [3:0] led, input logic tick);
    compared++;
    assert (oLED === led) else begin
      mismatched++;
      $error("FAIL %s oLED: observed %b expected %b", tag, oLED, led);
    end
    compared++;
    assert (oTICK === tick) else begin
      mismatched++;
      $error("FAIL %s oTICK: observed %b expected %b", tag, oTICK, tick);
    end
  endtask

  // From a point where the prescaler is 0: three quiet cycles, then the tick.
  task automatic nextTick(input string tag, input logic [3:0] led);
    cyc(3);
    chk({tag, "_pre"}, expLed, 1'b0);
    cyc(1);
    chk(tag, led, 1'b1);
    expLed = led;
  endtask

  task automatic doReset(input logic [1:0] mode);
    iRST = 1'b1;
    iEN  = 1'b1;
    cyc(2);
    iRST  = 1'b0;
    iMODE = mode;
    expLed = 4'b1000;
    chk("reset", 4'b1000, 1'b0);
  endtask

  initial begin
    // 1: rotate right, plus the small instance's first tick
    doReset(2'b00);
    compared++;
    assert (led2 === 3'b100) else begin
      mismatched++;
      $error("FAIL dut2_reset: observed %b expected %b", led2, 3'b100);
    end
    cyc(3);
    compared++;
    assert (led2 === 3'b010 && tick2 === 1'b1) else begin
      mismatched++;
      $error("FAIL dut2_tick: observed %b/%b expected 010/1", led2, tick2);
    end
    chk("rr_pre1", 4'b1000, 1'b0);
    cyc(1);
    chk("rr_t1", 4'b0100, 1'b1);
    expLed = 4'b0100;
    cyc(1);
    chk("rr_strobe_end", 4'b0100, 1'b0);
    cyc(2);
    cyc(1);
    chk("rr_t2", 4'b0010, 1'b1);
    expLed = 4'b0010;
    nextTick("rr_t3", 4'b0001);
    nextTick("rr_t4", 4'b1000);

    // 2: rotate left from reset (first tick is the mode load)
    doReset(2'b01);
    nextTick("rl_t1", 4'b0001);
    nextTick("rl_t2", 4'b0010);
    nextTick("rl_t3", 4'b0100);
    nextTick("rl_t4", 4'b1000);
    nextTick("rl_t5", 4'b0001);

    // 3: bounce
    doReset(2'b10);
    nextTick("bn_t1", 4'b1000);
    nextTick("bn_t2", 4'b0100);
    nextTick("bn_t3", 4'b0010);
    nextTick("bn_t4", 4'b0001);
    nextTick("bn_t5", 4'b0010);
    nextTick("bn_t6", 4'b0100);
    nextTick("bn_t7", 4'b1000);
    nextTick("bn_t8", 4'b0100);

    // 4: bar fill, then switch to rotate-right while empty
    doReset(2'b11);
    nextTick("bar_t1", 4'b0000);
    nextTick("bar_t2", 4'b1000);
    nextTick("bar_t3", 4'b1100);
    nextTick("bar_t4", 4'b1110);
    nextTick("bar_t5", 4'b1111);
    nextTick("bar_t6", 4'b0000);
    iMODE = 2'b00;
    nextTick("bar_sw00", 4'b1000);
    nextTick("bar_sw00_step", 4'b0100);

    // 5: pause at count 2, then iEN dropped exactly on the would-be tick
    doReset(2'b00);
    cyc(2);
    iEN = 1'b0;
    cyc(5);
    chk("pause_mid", 4'b1000, 1'b0);
    cyc(5);
    chk("pause_end", 4'b1000, 1'b0);
    iEN = 1'b1;
    cyc(1);
    chk("resume_1", 4'b1000, 1'b0);
    cyc(1);
    chk("resume_tick", 4'b0100, 1'b1);
    expLed = 4'b0100;
    cyc(3);
    iEN = 1'b0;
    cyc(1);
    chk("en_fall_on_max", 4'b0100, 1'b0);
    cyc(3);
    chk("en_fall_hold", 4'b0100, 1'b0);
    iEN = 1'b1;
    cyc(1);
    chk("en_fall_resume", 4'b0010, 1'b1);
    expLed = 4'b0010;

    // 6: reset on the tick cycle while bouncing left at 0100
    doReset(2'b10);
    nextTick("rst6_t1", 4'b1000);
    nextTick("rst6_t2", 4'b0100);
    nextTick("rst6_t3", 4'b0010);
    nextTick("rst6_t4", 4'b0001);
    nextTick("rst6_t5", 4'b0010);
    nextTick("rst6_t6", 4'b0100);
    cyc(3);
    iRST = 1'b1;
    cyc(1);
    chk("rst_on_tick", 4'b1000, 1'b0);
    iRST  = 1'b0;
    iMODE = 2'b01;
    expLed = 4'b1000;
    nextTick("after_rst_load", 4'b0001);
    nextTick("after_rst_step", 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/led_chaser_multi.md
Name: led_chaser_multi

Overview:
- Parametrised LED pattern generator for the board LED bank.
- A free-running prescaler divides the system clock down to a step tick. On each tick the output pattern advances according to one of four run-time selectable modes: rotate right, rotate left, bounce, and bar fill.
- Adds a synchronous reset, an enable/pause input and a step strobe output.
- Sits directly between the board clock and the LED pins, or feeds a downstream display mux via oTICK.

Parameters:
WIDTH, 8, number of LEDs; must be >= 2
DIV, 524288, system clock cycles per pattern step; must be >= 2
CNT_W, $clog2(DIV), prescaler counter width (derived; not overridden)

Ports:
iCLK  input  1  system clock; all logic on its rising edge
iRST  input  1  synchronous reset, active-high
iEN  input  1  1 = prescaler counts and pattern advances; 0 = freeze
iMODE  input  2  00 rotate-right, 01 rotate-left, 10 bounce, 11 bar fill
oLED  output  WIDTH  LED pattern, registered
oTICK  output  1  one-cycle strobe, high in the cycle oLED takes a new value

Behaviour:
- Single clock iCLK. Reset iRST is synchronous and active-high; it overrides everything else.
- Reset values:
  - oLED = 1 << (WIDTH-1), i.e. MSB only.
  - prescaler = 0, oTICK = 0.
  - Internal mode register = 00.
  - Bounce direction register = right.
- Prescaler:
  - When iEN=1, counts 0..DIV-1 and wraps to 0.
  - tick = (iEN=1 and count==DIV-1). The first tick after reset is on the DIV-th enabled cycle.
- Freeze: when iEN=0, the prescaler, oLED, mode register and direction register all hold. oTICK = 0. No partial-count loss; counting resumes from the held value.
- oTICK: registered, equal to tick delayed one edge, so it is high in the same cycle the new oLED is visible.
- Mode sampling:
  - iMODE is sampled only on tick.
  - If iMODE differs from the mode register on a tick, that tick updates the mode register and loads the new mode's start pattern; no shift occurs that tick.
  - Start patterns: 00 -> MSB only; 01 -> LSB only; 10 -> MSB only with direction = right; 11 -> all zeros.
  - If iMODE equals the mode register, the tick performs the mode's step.
- Step rules (W = WIDTH):
  - 00 rotate-right: oLED = {oLED[0], oLED[W-1:1]}. The LSB wraps to the MSB.
  - 01 rotate-left: oLED = {oLED[W-2:0], oLED[W-1]}. The MSB wraps to the LSB.
  - 10 bounce, moving right: shift right. If the new pattern has bit0 set, the direction becomes left.
  - 10 bounce, moving left: shift left. If the new pattern has bit W-1 set, the direction becomes right.
  - 10 bounce sequence: a single dot. The end positions appear once per pass and there is no dwell at the ends.
  - 11 bar fill, oLED != all-ones: oLED = {1'b1, oLED[W-1:1]} (fills from the MSB downward).
  - 11 bar fill, oLED == all-ones: oLED = 0. Sequence period is W+1 steps.
- Robustness: in modes 00/01/10, if oLED == 0 at a step (only reachable via a mode switch from 11), load that mode's start pattern instead of shifting.
- Simultaneous events: iRST with tick -> reset wins and oTICK = 0 next cycle. iEN falling in the same cycle as count==DIV-1 -> no tick.
- Reset mid-pattern returns to the MSB-only pattern regardless of mode. The new iMODE takes effect at the first tick after reset.

Test Plan:
All scenarios use WIDTH=4, DIV=4 unless noted.
1. Reset then iEN=1, iMODE=00 -> oLED 1000 after reset; first oTICK on the 4th enabled cycle with oLED=0100; then 0010, 0001, 1000 every 4 cycles.
2. iMODE=01 held from reset -> first tick loads 0001 (mode switch, no shift); then 0010, 0100, 1000, 0001.
3. iMODE=10 -> first tick 1000 (start), then 0100, 0010, 0001, 0010, 0100, 1000, 0100; direction flips exactly at 0001 and 1000.
4. iMODE=11 -> first tick 0000, then 1000, 1100, 1110, 1111, 0000, 1000; switching to 00 while at 0000 reloads 1000 at the next step.
5. Pause: drop iEN for 10 cycles at count=2 -> oLED and oTICK are frozen. The next tick comes exactly 2 enabled cycles after iEN returns; total ticks equal enabled cycles / 4.
6. Reset mid-run in mode 10 moving left at 0100, with iRST asserted on the tick cycle -> next cycle oLED=1000, oTICK=0, prescaler 0. Repeat with the default DIV, checking the first tick after exactly 524288 enabled cycles.
